// File: rtl/multicycle_controller_if.sv
// Control bus between the multi-cycle sequencer and the shared datapath.
// The controller side (master) receives the instruction fields and the memory
// handshake and drives every per-state control line; the datapath side (slave)
// sees the mirror image.
interface multicycle_controller_if;
  logic [5:0] Op;
  logic [5:0] Fcn;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IRWrite;
  logic       ALUSrc;
  logic       ALUSrc2;
  logic       RegDst;
  logic       RegWrite;
  logic [3:0] ALUOp;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IllegalOp;
  logic [3:0] State;

  modport master (
    input  Op, Fcn, MemReady,
    output PCWrite, PCWriteCond, IRWrite, ALUSrc, ALUSrc2, RegDst, RegWrite,
           ALUOp, MemRead, MemWrite, MemtoReg, IllegalOp, State
  );

  modport slave (
    output Op, Fcn, MemReady,
    input  PCWrite, PCWriteCond, IRWrite, ALUSrc, ALUSrc2, RegDst, RegWrite,
           ALUOp, MemRead, MemWrite, MemtoReg, IllegalOp, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle sequencer for the shared ALU / register-file / memory datapath.
// Walks FETCH/DECODE/EXEC/MEM/WB, stalls on MemReady, runs a counted multiply
// and flags unrecognised instructions with a sticky IllegalOp. Control outputs
// are combinational from the current state, the Op/Fcn latched in DECODE and
// MemReady; the state, latched fields, counter and IllegalOp are registered.
module multicycle_controller #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_EXEC_MUL = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_ALU   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_BRANCH   = 4'd11
  } state_t;

  // Instruction classes produced by the decoder
  localparam logic [2:0] CLS_ILL = 3'd0;
  localparam logic [2:0] CLS_R   = 3'd1;
  localparam logic [2:0] CLS_MUL = 3'd2;
  localparam logic [2:0] CLS_I   = 3'd3;
  localparam logic [2:0] CLS_LD  = 3'd4;
  localparam logic [2:0] CLS_ST  = 3'd5;
  localparam logic [2:0] CLS_BR  = 3'd6;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  // Map an Op/Fcn pair onto its instruction class
  function automatic logic [2:0] op_class(input logic [5:0] op, input logic [5:0] fcn);
    logic [2:0] cls;
    cls = CLS_ILL;
    case (op)
      6'h00: begin
        case (fcn)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h06: cls = CLS_R;
          default: cls = CLS_ILL;
        endcase
      end
      6'h1C: begin
        case (fcn)
          6'h21, 6'h20: cls = CLS_R;
          6'h02:        cls = CLS_MUL;
          default:      cls = CLS_ILL;
        endcase
      end
      6'h08, 6'h0D: cls = CLS_I;
      6'h23:        cls = CLS_LD;
      6'h2B:        cls = CLS_ST;
      6'h05:        cls = CLS_BR;
      default:      cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // ALU operation selected by an execute-class instruction
  function automatic logic [3:0] alu_op_of(input logic [5:0] op, input logic [5:0] fcn);
    logic [3:0] alu;
    alu = ALU_ADD;
    case (op)
      6'h00: begin
        case (fcn)
          6'h20:   alu = 4'h0;
          6'h22:   alu = 4'h1;
          6'h24:   alu = 4'h2;
          6'h25:   alu = 4'h3;
          6'h2A:   alu = 4'h4;
          6'h00:   alu = 4'h5;
          6'h02:   alu = 4'h6;
          6'h06:   alu = 4'h7;
          default: alu = ALU_ADD;
        endcase
      end
      6'h1C: begin
        case (fcn)
          6'h21:   alu = 4'h8;
          6'h20:   alu = 4'h9;
          6'h02:   alu = 4'hA;
          default: alu = ALU_ADD;
        endcase
      end
      6'h0D:   alu = 4'h3;
      default: alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Shifts and rotate take the shamt field on ALU input A
  function automatic logic is_shift(input logic [5:0] op, input logic [5:0] fcn);
    return (op == 6'h00) && ((fcn == 6'h00) || (fcn == 6'h02) || (fcn == 6'h06));
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] op_r;
  logic [5:0] fcn_r;
  logic [3:0] cnt_r;
  logic       illegal_r;

  logic       pc_write_s;
  logic       pc_write_cond_s;
  logic       ir_write_s;
  logic       alu_src_s;
  logic       alu_src2_s;
  logic       reg_dst_s;
  logic       reg_write_s;
  logic [3:0] alu_op_s;
  logic       mem_read_s;
  logic       mem_write_s;
  logic       mem_to_reg_s;

  // State register; Reset overrides every transition
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the instruction fields in DECODE and raise the sticky illegal flag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_r      <= 6'h00;
      fcn_r     <= 6'h00;
      illegal_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      op_r  <= bus.Op;
      fcn_r <= bus.Fcn;
      if (op_class(bus.Op, bus.Fcn) == CLS_ILL) begin
        illegal_r <= 1'b1;
      end
    end
  end

  // Multiply cycle counter: zero outside EXEC_MUL, so it starts at 0 on entry
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r <= 4'd0;
    end else if (state_r == S_EXEC_MUL) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= 4'd0;
    end
  end

  // Next-state selection and per-state control outputs
  always_comb begin
    state_nxt_s     = state_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    ir_write_s      = 1'b0;
    alu_src_s       = 1'b0;
    alu_src2_s      = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_op_s        = ALU_ADD;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    case (state_r)
      S_INIT: begin
        state_nxt_s = S_FETCH;
      end
      S_FETCH: begin
        mem_read_s = 1'b1;
        ir_write_s = bus.MemReady;
        pc_write_s = bus.MemReady;
        if (bus.MemReady) begin
          state_nxt_s = S_DECODE;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op_class(bus.Op, bus.Fcn))
          CLS_R:          state_nxt_s = S_EXEC_R;
          CLS_MUL:        state_nxt_s = S_EXEC_MUL;
          CLS_I:          state_nxt_s = S_EXEC_I;
          CLS_LD, CLS_ST: state_nxt_s = S_MEM_ADDR;
          CLS_BR:         state_nxt_s = S_BRANCH;
          default:        state_nxt_s = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        alu_op_s    = alu_op_of(op_r, fcn_r);
        alu_src2_s  = is_shift(op_r, fcn_r);
        state_nxt_s = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_s   = 1'b1;
        alu_op_s    = alu_op_of(op_r, fcn_r);
        state_nxt_s = S_WB_ALU;
      end
      S_EXEC_MUL: begin
        alu_op_s = alu_op_of(op_r, fcn_r);
        if (cnt_r == MUL_LAST) begin
          state_nxt_s = S_WB_ALU;
        end else begin
          state_nxt_s = S_EXEC_MUL;
        end
      end
      S_MEM_ADDR: begin
        alu_src_s = 1'b1;
        alu_op_s  = ALU_ADD;
        if (op_r == 6'h2B) begin
          state_nxt_s = S_MEM_WR;
        end else begin
          state_nxt_s = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_read_s = 1'b1;
        alu_src_s  = 1'b1;
        alu_op_s   = ALU_ADD;
        if (bus.MemReady) begin
          state_nxt_s = S_WB_MEM;
        end else begin
          state_nxt_s = S_MEM_RD;
        end
      end
      S_MEM_WR: begin
        mem_write_s = 1'b1;
        alu_src_s   = 1'b1;
        alu_op_s    = ALU_ADD;
        if (bus.MemReady) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_MEM_WR;
        end
      end
      S_WB_ALU: begin
        reg_write_s = 1'b1;
        alu_op_s    = alu_op_of(op_r, fcn_r);
        reg_dst_s   = (op_class(op_r, fcn_r) != CLS_I);
        alu_src_s   = (op_class(op_r, fcn_r) == CLS_I);
        alu_src2_s  = is_shift(op_r, fcn_r);
        state_nxt_s = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_nxt_s  = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_s        = ALU_SUB;
        pc_write_cond_s = 1'b1;
        state_nxt_s     = S_FETCH;
      end
      default: begin
        state_nxt_s = S_INIT;
      end
    endcase
  end

  assign bus.PCWrite     = pc_write_s;
  assign bus.PCWriteCond = pc_write_cond_s;
  assign bus.IRWrite     = ir_write_s;
  assign bus.ALUSrc      = alu_src_s;
  assign bus.ALUSrc2     = alu_src2_s;
  assign bus.RegDst      = reg_dst_s;
  assign bus.RegWrite    = reg_write_s;
  assign bus.ALUOp       = alu_op_s;
  assign bus.MemRead     = mem_read_s;
  assign bus.MemWrite    = mem_write_s;
  assign bus.MemtoReg    = mem_to_reg_s;
  assign bus.IllegalOp   = illegal_r;
  assign bus.State       = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: a fixed table for the basic add flow,
// directed sequences for stalls, multiply, branch, illegal-op and reset abort,
// then random instruction streams checked against a per-instruction trace model.
module tb_multicycle_controller;

  localparam int MUL_CYCLES = 4;

  localparam int K_ILL = 0;
  localparam int K_R   = 1;
  localparam int K_MUL = 2;
  localparam int K_I   = 3;
  localparam int K_LD  = 4;
  localparam int K_ST  = 5;
  localparam int K_BR  = 6;

  typedef struct {
    string       tag;
    logic        rst;
    logic        mr;
    logic [5:0]  op;
    logic [5:0]  fcn;
    logic [18:0] exp;
  } vec_t;

  logic Clk;
  logic Reset;
  int   n_vec;
  int   n_err;
  logic ill_m;
  vec_t q[$];
  vec_t tbl[6];

  multicycle_controller_if bus ();

  multicycle_controller #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Pack one cycle's expected outputs in a fixed order
  function automatic logic [18:0] make_exp(
      input logic pcw, input logic pcwc, input logic irw, input logic src,
      input logic src2, input logic rd, input logic rw, input logic [3:0] alu,
      input logic mrd, input logic mwr, input logic m2r, input logic ill,
      input logic [3:0] st);
    return {pcw, pcwc, irw, src, src2, rd, rw, alu, mrd, mwr, m2r, ill, st};
  endfunction

  // Instruction-set rules: class, ALU operation, shamt use
  function automatic void classify(input logic [5:0] op, input logic [5:0] fcn,
                                   output int kind, output logic [3:0] alu,
                                   output logic sh);
    kind = K_ILL;
    alu  = 4'h0;
    sh   = 1'b0;
    if (op == 6'h00) begin
      kind = K_R;
      if (fcn == 6'h20) alu = 4'h0;
      else if (fcn == 6'h22) alu = 4'h1;
      else if (fcn == 6'h24) alu = 4'h2;
      else if (fcn == 6'h25) alu = 4'h3;
      else if (fcn == 6'h2A) alu = 4'h4;
      else if (fcn == 6'h00) begin alu = 4'h5; sh = 1'b1; end
      else if (fcn == 6'h02) begin alu = 4'h6; sh = 1'b1; end
      else if (fcn == 6'h06) begin alu = 4'h7; sh = 1'b1; end
      else kind = K_ILL;
    end else if (op == 6'h1C) begin
      if (fcn == 6'h21) begin kind = K_R; alu = 4'h8; end
      else if (fcn == 6'h20) begin kind = K_R; alu = 4'h9; end
      else if (fcn == 6'h02) begin kind = K_MUL; alu = 4'hA; end
    end else if (op == 6'h08) begin kind = K_I; alu = 4'h0; end
    else if (op == 6'h0D) begin kind = K_I; alu = 4'h3; end
    else if (op == 6'h23) kind = K_LD;
    else if (op == 6'h2B) kind = K_ST;
    else if (op == 6'h05) kind = K_BR;
  endfunction

  task automatic push(input string tag, input logic rst, input logic mr,
                      input logic [5:0] op, input logic [5:0] fcn, input logic [18:0] e);
    vec_t v;
    v.tag = tag; v.rst = rst; v.mr = mr; v.op = op; v.fcn = fcn; v.exp = e;
    q.push_back(v);
  endtask

  function automatic logic [5:0] junk6();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace of one instruction, starting in FETCH. Op/Fcn carry
  // the real instruction only in DECODE, so later states must use the latched copy.
  task automatic add_instr(input string tag, input logic [5:0] op, input logic [5:0] fcn,
                           input int fstall, input int mstall, input logic rst_in_wait);
    int kind;
    logic [3:0] alu;
    logic sh;
    for (int i = 0; i < fstall; i++)
      push({tag, "_fetch_wait"}, 1'b0, 1'b0, junk6(), junk6(),
           make_exp(0,0,0,0,0,0,0,4'h0,1,0,0,ill_m,4'd1));
    push({tag, "_fetch"}, 1'b0, 1'b1, junk6(), junk6(),
         make_exp(1,0,1,0,0,0,0,4'h0,1,0,0,ill_m,4'd1));
    push({tag, "_decode"}, 1'b0, rbit(), op, fcn,
         make_exp(0,0,0,0,0,0,0,4'h0,0,0,0,ill_m,4'd2));
    classify(op, fcn, kind, alu, sh);
    case (kind)
      K_R: begin
        push({tag, "_exec_r"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,0,sh,0,0,alu,0,0,0,ill_m,4'd3));
        push({tag, "_wb_alu"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,0,sh,1,1,alu,0,0,0,ill_m,4'd9));
      end
      K_MUL: begin
        for (int i = 0; i < MUL_CYCLES; i++)
          push({tag, "_exec_mul"}, 1'b0, rbit(), junk6(), junk6(),
               make_exp(0,0,0,0,0,0,0,4'hA,0,0,0,ill_m,4'd5));
        push({tag, "_wb_alu"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,0,0,1,1,4'hA,0,0,0,ill_m,4'd9));
      end
      K_I: begin
        push({tag, "_exec_i"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,1,0,0,0,alu,0,0,0,ill_m,4'd4));
        push({tag, "_wb_alu"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,1,0,0,1,alu,0,0,0,ill_m,4'd9));
      end
      K_LD: begin
        push({tag, "_mem_addr"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,1,0,0,0,4'h0,0,0,0,ill_m,4'd6));
        for (int i = 0; i < mstall; i++)
          push({tag, "_mem_rd_wait"}, 1'b0, 1'b0, junk6(), junk6(),
               make_exp(0,0,0,1,0,0,0,4'h0,1,0,0,ill_m,4'd7));
        push({tag, "_mem_rd"}, 1'b0, 1'b1, junk6(), junk6(),
             make_exp(0,0,0,1,0,0,0,4'h0,1,0,0,ill_m,4'd7));
        push({tag, "_wb_mem"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,0,0,0,1,4'h0,0,0,1,ill_m,4'd10));
      end
      K_ST: begin
        push({tag, "_mem_addr"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,0,0,1,0,0,0,4'h0,0,0,0,ill_m,4'd6));
        for (int i = 0; i < mstall; i++)
          push({tag, "_mem_wr_wait"}, 1'b0, 1'b0, junk6(), junk6(),
               make_exp(0,0,0,1,0,0,0,4'h0,0,1,0,ill_m,4'd8));
        if (rst_in_wait) begin
          push({tag, "_mem_wr_reset"}, 1'b1, 1'b0, junk6(), junk6(),
               make_exp(0,0,0,1,0,0,0,4'h0,0,1,0,ill_m,4'd8));
          ill_m = 1'b0;
          push({tag, "_init"}, 1'b0, rbit(), junk6(), junk6(),
               make_exp(0,0,0,0,0,0,0,4'h0,0,0,0,1'b0,4'd0));
        end else begin
          push({tag, "_mem_wr"}, 1'b0, 1'b1, junk6(), junk6(),
               make_exp(0,0,0,1,0,0,0,4'h0,0,1,0,ill_m,4'd8));
        end
      end
      K_BR: begin
        push({tag, "_branch"}, 1'b0, rbit(), junk6(), junk6(),
             make_exp(0,1,0,0,0,0,0,4'h1,0,0,0,ill_m,4'd11));
      end
      default: begin
        ill_m = 1'b1;
      end
    endcase
  endtask

  task automatic apply(input vec_t v);
    logic [18:0] got;
    @(negedge Clk);
    Reset        = v.rst;
    bus.MemReady = v.mr;
    bus.Op       = v.op;
    bus.Fcn      = v.fcn;
    #1;
    got = {bus.PCWrite, bus.PCWriteCond, bus.IRWrite, bus.ALUSrc, bus.ALUSrc2,
           bus.RegDst, bus.RegWrite, bus.ALUOp, bus.MemRead, bus.MemWrite,
           bus.MemtoReg, bus.IllegalOp, bus.State};
    n_vec++;
    if (got !== v.exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %05h required %05h (state got %0d required %0d)",
               v.tag, n_vec, got, v.exp, got[3:0], v.exp[3:0]);
    end
  endtask

  task automatic run_queue();
    while (q.size() > 0) begin
      apply(q.pop_front());
    end
  endtask

  logic [5:0] legal_op[16];
  logic [5:0] legal_fcn[16];

  initial begin
    n_vec = 0;
    n_err = 0;
    ill_m = 1'b0;
    Reset = 1'b1;
    bus.MemReady = 1'b1;
    bus.Op  = 6'h00;
    bus.Fcn = 6'h20;

    // Reset then add r-type: INIT, FETCH, DECODE, EXEC_R, WB_ALU, FETCH
    tbl[0] = '{tag:"t1_init",   rst:1'b0, mr:1'b1, op:6'h00, fcn:6'h20,
               exp:make_exp(0,0,0,0,0,0,0,4'h0,0,0,0,0,4'd0)};
    tbl[1] = '{tag:"t1_fetch",  rst:1'b0, mr:1'b1, op:6'h00, fcn:6'h20,
               exp:make_exp(1,0,1,0,0,0,0,4'h0,1,0,0,0,4'd1)};
    tbl[2] = '{tag:"t1_decode", rst:1'b0, mr:1'b1, op:6'h00, fcn:6'h20,
               exp:make_exp(0,0,0,0,0,0,0,4'h0,0,0,0,0,4'd2)};
    tbl[3] = '{tag:"t1_exec_r", rst:1'b0, mr:1'b1, op:6'h00, fcn:6'h20,
               exp:make_exp(0,0,0,0,0,0,0,4'h0,0,0,0,0,4'd3)};
    tbl[4] = '{tag:"t1_wb_alu", rst:1'b0, mr:1'b1, op:6'h00, fcn:6'h20,
               exp:make_exp(0,0,0,0,0,1,1,4'h0,0,0,0,0,4'd9)};
    tbl[5] = '{tag:"t1_fetch2", rst:1'b0, mr:1'b0, op:6'h00, fcn:6'h20,
               exp:make_exp(0,0,0,0,0,0,0,4'h0,1,0,0,0,4'd1)};

    @(posedge Clk);
    for (int i = 0; i < 6; i++) apply(tbl[i]);

    // Directed corner cases
    add_instr("t2_lw",   6'h23, 6'h00, 0, 3, 1'b0);
    add_instr("t3_mul",  6'h1C, 6'h02, 1, 0, 1'b0);
    add_instr("t4_bne",  6'h05, 6'h11, 0, 0, 1'b0);
    add_instr("t4_sll",  6'h00, 6'h00, 2, 0, 1'b0);
    add_instr("t5_ill",  6'h3F, 6'h00, 0, 0, 1'b0);
    add_instr("t5_addi", 6'h08, 6'h15, 0, 0, 1'b0);
    add_instr("t6_sw",   6'h2B, 6'h00, 0, 2, 1'b1);
    add_instr("t6_ori",  6'h0D, 6'h00, 0, 0, 1'b0);
    add_instr("t6_sw_ok",6'h2B, 6'h07, 1, 1, 1'b0);
    run_queue();

    // Random instruction stream
    legal_op  = '{6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                  6'h1C,6'h1C,6'h1C,6'h08,6'h0D,6'h23,6'h2B,6'h05};
    legal_fcn = '{6'h20,6'h22,6'h24,6'h25,6'h2A,6'h00,6'h02,6'h06,
                  6'h21,6'h20,6'h02,6'h00,6'h00,6'h00,6'h00,6'h00};
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [5:0] fcn;
      int idx;
      if ($urandom_range(0, 7) == 0) begin
        op  = junk6();
        fcn = junk6();
      end else begin
        idx = $urandom_range(0, 15);
        op  = legal_op[idx];
        fcn = (idx >= 11) ? junk6() : legal_fcn[idx];
      end
      add_instr("rnd", op, fcn, $urandom_range(0, 3), $urandom_range(0, 3),
                (op == 6'h2B) && ($urandom_range(0, 9) == 0));
      run_queue();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
